// File: rtl/instr_issue_seq.sv
// instr_issue_seq: instruction sequencer feeding a 2-bit-opcode decode stage.
// Holds a small writable program store, walks it with a PC and presents one instruction at a
// time with a valid/stall handshake. Opcode 10 (HALT) is consumed here and never issued.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   prog_we/addr/data     program store write port (honoured only in IDLE or HALT)
//   start                 1-cycle pulse, begin execution at PC 0 (ignored while busy)
//   stall                 downstream not accepting this cycle
//   issue_valid           opcode_o/operand_o carry a real instruction
//   opcode_o, operand_o   instruction fields; 11 / 0 whenever issue_valid=0
//   pc_o                  address of the instruction currently held
//   busy, halted          state is FETCH/ISSUE, state is HALT
module instr_issue_seq #(
  parameter int unsigned IW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic          stall,
  output logic          issue_valid,
  output logic [1:0]    opcode_o,
  output logic [IW-3:0] operand_o,
  output logic [AW-1:0] pc_o,
  output logic          busy,
  output logic          halted
);

  localparam logic [1:0]    OpHalt = 2'b10;
  localparam logic [1:0]    OpNop  = 2'b11;
  localparam logic [AW-1:0] PcMax  = '1;

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [1:0]    op_q, op_d;
  logic [IW-3:0] opr_q, opr_d;

  logic [IW-1:0] mem [2**AW];
  logic [IW-1:0] fetch_word;

  // Store is not reset; writes only land while the sequencer is not walking it.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == StIdle || state_q == StHalt)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign fetch_word = mem[pc_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    op_d    = op_q;
    opr_d   = opr_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Decode at fetch so the ISSUE cycle already drives registered outputs.
        // A HALT word leaves issue_valid low and is never presented downstream.
        state_d = StIssue;
        if (fetch_word[IW-1:IW-2] != OpHalt) begin
          valid_d = 1'b1;
          op_d    = fetch_word[IW-1:IW-2];
          opr_d   = fetch_word[IW-3:0];
        end
      end
      StIssue: begin
        if (!valid_q) begin
          state_d = StHalt;
        end else if (!stall) begin
          valid_d = 1'b0;
          op_d    = OpNop;
          opr_d   = '0;
          // End of store forces HALT instead of wrapping the PC.
          if (pc_q == PcMax) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      valid_q <= 1'b0;
      op_q    <= OpNop;
      opr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      opr_q   <= opr_d;
    end
  end

  assign issue_valid = valid_q;
  assign opcode_o    = op_q;
  assign operand_o   = opr_q;
  assign pc_o        = pc_q;
  assign busy        = (state_q == StFetch) || (state_q == StIssue);
  assign halted      = (state_q == StHalt);

endmodule
